pid_scheduler: RTL and testbench
================================

// Module: pid_scheduler
// PURPOSE
//  Time-shares one incremental-PID arithmetic path across NUM_CH wheel-motor channels.
//  On each sample_tick it snapshots every channel's target and encoder count, then visits channels in order 0..NUM_CH-1.
//  For each channel it computes u = u_prev + K1*e - K2*e1 + K3*e2, saturates the result to a 7-bit magnitude, and updates that channel's pwm/brake outputs.
//  Sits between the command decoder (targets) and the per-wheel PWM generators.
// PARAMETERS
//  NUM_CH   4     number of motor channels serviced per sweep (1..8)
//  K1       15    gain on current error e
//  K2       16    gain on previous error e1
//  K3       0     gain on error two samples back e2
//  U_CLAMP  1023  magnitude limit on stored u_prev (anti-windup)
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  reset        in   1          synchronous, active-high
//  sample_tick  in   1          1-cycle strobe that starts a sweep
//  target_flat  in   8*NUM_CH   ch k at [8k+7:8k]; bit7 = direction, [6:0] = speed
//  enc_flat     in   7*NUM_CH   ch k at [7k+6:7k]; measured speed per sample
//  pwm_flat     out  8*NUM_CH   ch k at [8k+7:8k]; bit7 = direction, [6:0] = duty 0..127
//  brake        out  NUM_CH     1 = brake channel k
//  busy         out  1          sweep in progress
//  done         out  1          1-cycle pulse when the last channel is stored
//  overrun      out  1          sticky: sample_tick arrived while busy
// BEHAVIOUR
//  Reset values:
//   - pwm_flat = 0, brake = all 1s (safe), busy = 0, done = 0, overrun = 0
//   - all per-channel e1, e2, u_prev = 0; FSM in IDLE; ch index = 0
//  FSM states: IDLE, LOAD, CALC, STORE.
//   - IDLE: on sample_tick, register target_flat/enc_flat into a snapshot, set ch = 0 and busy = 1, go to LOAD.
//   - LOAD: e = {0,target[6:0]} - {0,enc}, signed 18-bit; fetch e1, e2, u_prev[ch]. Go to CALC.
//   - CALC: u = u_prev + K1*e - K2*e1 + K3*e2, signed 18-bit, no wrap for the default gains. Go to STORE.
//   - STORE:
//       * pwm[ch][6:0] = 0 if u < 0; 127 if u > 127; else u[6:0]
//       * pwm[ch][7] = snapshot target[7]
//       * brake[ch] = (snapshot target == 8'd0)
//       * state update: e2 <= e1, e1 <= e, u_prev <= u clamped to [-U_CLAMP, +U_CLAMP]
//       * if ch == NUM_CH-1: done = 1 for this cycle, busy = 0, go to IDLE
//       * else: ch++, go to LOAD
//  Brake channel: when snapshot target == 0, the STORE cycle instead forces pwm[ch] = 0 and clears e1/e2/u_prev[ch] to 0.
//  Latency:
//   - tick to channel k output = 3k+3 cycles; tick to done = 3*NUM_CH cycles
//   - back-to-back ticks are accepted 1 cycle after done
//  Outputs of channel k change only in its STORE cycle; all other channels hold.
//  Snapshot is taken only at sweep start; input changes mid-sweep have no effect until the next sweep.
//  sample_tick while busy: ignored; the sweep continues unaffected and overrun = 1 until reset.
//  sample_tick in the same cycle as done: treated as busy, so it is ignored and sets overrun.
//  reset mid-sweep: next cycle is IDLE with the reset values above; no partial state write survives.
// TESTING
//  All checks use NUM_CH=4 and default gains.
//  1 reset -> pwm_flat=0, brake=4'hF, busy=0, overrun=0; holds with no tick
//  2 ch0 target=8'd50, enc=0, tick -> at cycle 3: pwm ch0=8'd127 (u=750), brake[0]=0; done at cycle 12
//    second identical tick -> u=750+750-800=700, pwm ch0=127
//  3 ch1 target=8'h8A, enc=2, from reset -> u=120, pwm ch1=8'hF8 at cycle 6
//  4 ch2 target=8'd10, enc=20 -> u=-150, pwm ch2=0
//    then ch2 target=0 -> brake[2]=1, pwm ch2=0; next nonzero sweep starts from zeroed state
//  5 tick at cycle 4 of a sweep -> overrun=1, done still at cycle 12, outputs match the no-overrun run
//  6 reset asserted at cycle 5 -> cycle 6: busy=0, pwm_flat=0, brake=4'hF; the next sweep behaves as if from power-up

Source files
------------

// File: rtl/pid_scheduler.sv
// pid_scheduler: one incremental-PID datapath shared across NUM_CH motor channels.
// A sample_tick snapshots all targets/encoder counts, then channels are visited
// in order 0..NUM_CH-1. Each visit takes three cycles: LOAD -> CALC -> STORE.
//
// Strobe semantics: sample_tick is a single-cycle request with no ready/ack.
// It is accepted only in IDLE when the previous sweep's done pulse is not
// showing. A tick seen while busy, or in the done cycle, is dropped and sets
// the sticky overrun flag.
module pid_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int K1      = 15,
  parameter int K2      = 16,
  parameter int K3      = 0,
  parameter int U_CLAMP = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic [8*NUM_CH-1:0]   target_flat,
  input  logic [7*NUM_CH-1:0]   enc_flat,
  output logic [8*NUM_CH-1:0]   pwm_flat,
  output logic [NUM_CH-1:0]     brake,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [1:0]            dbg_state_o
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
  localparam logic signed [17:0] K1_S   = 18'(K1);
  localparam logic signed [17:0] K2_S   = 18'(K2);
  localparam logic signed [17:0] K3_S   = 18'(K3);
  localparam logic signed [17:0] UCLAMP = 18'(U_CLAMP);
  localparam logic signed [17:0] DUTY_MAX = 18'sd127;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CALC  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]          ch_q;
  logic [8*NUM_CH-1:0]    tgt_snap_q;
  logic [7*NUM_CH-1:0]    enc_snap_q;
  logic [8*NUM_CH-1:0]    pwm_q;
  logic [NUM_CH-1:0]      brake_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   overrun_q;

  // Per-channel controller history.
  logic signed [17:0]     e1_mem_q [NUM_CH];
  logic signed [17:0]     e2_mem_q [NUM_CH];
  logic signed [17:0]     up_mem_q [NUM_CH];

  // Working registers for the channel currently being serviced.
  logic signed [17:0]     e_q, e1_q, e2_q, up_q, u_q;

  logic [7:0]             cur_tgt;
  logic [6:0]             cur_enc;
  logic                   last_ch;
  logic                   tick_accept;
  logic signed [17:0]     e_calc;
  logic signed [17:0]     u_calc;
  logic signed [17:0]     u_clamped;
  logic [6:0]             duty;

  assign cur_tgt     = tgt_snap_q[8*ch_q +: 8];
  assign cur_enc     = enc_snap_q[7*ch_q +: 7];
  assign last_ch     = (ch_q == LAST_CH);
  assign tick_accept = sample_tick && (state_q == S_IDLE) && !done_q;

  // Error and control law; 18-bit signed arithmetic never wraps for the default gains.
  assign e_calc = $signed({11'd0, cur_tgt[6:0]}) - $signed({11'd0, cur_enc});
  assign u_calc = up_q + K1_S * e_q - K2_S * e1_q + K3_S * e2_q;

  // Anti-windup clamp on the stored u and duty saturation on the output.
  always_comb begin
    u_clamped = u_q;
    if (u_q > UCLAMP)
      u_clamped = UCLAMP;
    else if (u_q < -UCLAMP)
      u_clamped = -UCLAMP;
    duty = u_q[6:0];
    if (u_q < 18'sd0)
      duty = 7'd0;
    else if (u_q > DUTY_MAX)
      duty = 7'd127;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: fixed LOAD/CALC/STORE cadence per channel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tick_accept) state_d = S_LOAD;
      S_LOAD:  state_d = S_CALC;
      S_CALC:  state_d = S_STORE;
      S_STORE: state_d = last_ch ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, per-channel history and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q       <= '0;
      tgt_snap_q <= '0;
      enc_snap_q <= '0;
      pwm_q      <= '0;
      brake_q    <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      e_q        <= '0;
      e1_q       <= '0;
      e2_q       <= '0;
      up_q       <= '0;
      u_q        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        e1_mem_q[i] <= '0;
        e2_mem_q[i] <= '0;
        up_mem_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (sample_tick && (busy_q || done_q))
        overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (tick_accept) begin
            tgt_snap_q <= target_flat;
            enc_snap_q <= enc_flat;
            ch_q       <= '0;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          e_q  <= e_calc;
          e1_q <= e1_mem_q[ch_q];
          e2_q <= e2_mem_q[ch_q];
          up_q <= up_mem_q[ch_q];
        end
        S_CALC: begin
          u_q <= u_calc;
        end
        S_STORE: begin
          if (cur_tgt == 8'd0) begin
            // Braked channel: zero drive and forget controller history.
            pwm_q[8*ch_q +: 8] <= 8'd0;
            brake_q[ch_q]      <= 1'b1;
            e1_mem_q[ch_q]     <= '0;
            e2_mem_q[ch_q]     <= '0;
            up_mem_q[ch_q]     <= '0;
          end else begin
            pwm_q[8*ch_q +: 8] <= {cur_tgt[7], duty};
            brake_q[ch_q]      <= 1'b0;
            e2_mem_q[ch_q]     <= e1_q;
            e1_mem_q[ch_q]     <= e_q;
            up_mem_q[ch_q]     <= u_clamped;
          end
          if (last_ch) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign pwm_flat    = pwm_q;
  assign brake       = brake_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pid_scheduler.sv
// tb_pid_scheduler: sweep vectors with hand-derived expected pwm/brake per
// channel, a channel-order scoreboard queue, and corner sequences for
// overrun and mid-sweep reset.
module tb_pid_scheduler;

  localparam int NUM_CH = 4;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 sample_tick = 1'b0;
  logic [8*NUM_CH-1:0]  target_flat = '0;
  logic [7*NUM_CH-1:0]  enc_flat = '0;
  logic [8*NUM_CH-1:0]  pwm_flat;
  logic [NUM_CH-1:0]    brake;
  logic                 busy;
  logic                 done;
  logic                 overrun;
  logic [1:0]           dbg_state_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected {brake bit, pwm byte} per channel, in service order.
  logic [8:0] exp_q[$];
  logic [8*NUM_CH-1:0] exp_pwm = '0;
  logic [NUM_CH-1:0]   exp_brk = '1;

  typedef struct {
    logic [31:0] tgt;
    logic [27:0] enc;
    logic [31:0] pwm;
    logic [3:0]  brk;
  } vec_t;

  vec_t vecs[6];

  pid_scheduler #(.NUM_CH(NUM_CH)) dut (
    .clk(clk),
    .reset(reset),
    .sample_tick(sample_tick),
    .target_flat(target_flat),
    .enc_flat(enc_flat),
    .pwm_flat(pwm_flat),
    .brake(brake),
    .busy(busy),
    .done(done),
    .overrun(overrun),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pwm"},     64'(pwm_flat), 64'd0);
    chk({tag, "_brake"},   64'(brake), 64'hF);
    chk({tag, "_busy"},    64'(busy), 64'd0);
    chk({tag, "_done"},    64'(done), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    chk({tag, "_state"},   64'(dbg_state_o), 64'd0);
  endtask

  // One sweep: push expectations, tick, then check each STORE cycle,
  // the done pulse position and busy. Optional extra tick at cycle 4 or
  // reset sampled at cycle 6.
  task automatic run_sweep(input int v, input bit ovr_tick, input bit rst_mid);
    logic [8:0] e;
    int k;
    @(negedge clk);
    @(negedge clk);
    target_flat = vecs[v].tgt;
    enc_flat    = vecs[v].enc;
    sample_tick = 1'b1;
    for (int c = 0; c < NUM_CH; c++)
      exp_q.push_back({vecs[v].brk[c], vecs[v].pwm[8*c +: 8]});
    @(posedge clk); #1;
    sample_tick = 1'b0;
    for (int n = 1; n <= 3*NUM_CH; n++) begin
      @(posedge clk); #1;
      if (rst_mid && n == 6) begin
        chk_reset_state($sformatf("v%0d_midreset", v));
        reset = 1'b0;
        exp_q.delete();
        exp_pwm = '0;
        exp_brk = '1;
        return;
      end
      // Inputs changing mid-sweep must not affect this sweep.
      if (n == 1) begin
        target_flat = {$urandom, $urandom} & 32'hFFFF_FFFF;
        enc_flat    = 28'($urandom_range(0, 32'h0FFF_FFFF));
      end
      if (n % 3 == 0) begin
        k = n / 3 - 1;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL v%0d_sb_empty: got empty queue expected entry", v);
        end else begin
          e = exp_q.pop_front();
          exp_pwm[8*k +: 8] = e[7:0];
          exp_brk[k] = e[8];
        end
        chk($sformatf("v%0d_ch%0d_pwm", v, k), 64'(pwm_flat), 64'(exp_pwm));
        chk($sformatf("v%0d_ch%0d_brake", v, k), 64'(brake), 64'(exp_brk));
      end
      chk($sformatf("v%0d_done_c%0d", v, n), 64'(done), 64'(n == 3*NUM_CH));
      chk($sformatf("v%0d_busy_c%0d", v, n), 64'(busy), 64'(n < 3*NUM_CH));
      if (ovr_tick && n == 3) sample_tick = 1'b1;
      if (ovr_tick && n == 4) sample_tick = 1'b0;
      if (rst_mid && n == 5) reset = 1'b1;
    end
  endtask

  initial begin
    // Inputs {ch3..ch0}; expected outputs derived by hand from
    // u = u_prev + 15e - 16e1, duty saturated to 0..127, u_prev clamped to +/-1023.
    // A: ch0 50/0 -> 750; ch1 0x8A/2 -> 120; ch2 10/20 -> -150; ch3 brake
    vecs[0] = '{tgt: {8'h00, 8'd10, 8'h8A, 8'd50}, enc: {7'd0, 7'd20, 7'd2, 7'd0},
                pwm: {8'h00, 8'h00, 8'hF8, 8'h7F}, brk: 4'b1000};
    // B: repeat -> ch0 700, ch1 112, ch2 -140
    vecs[1] = '{tgt: {8'h00, 8'd10, 8'h8A, 8'd50}, enc: {7'd0, 7'd20, 7'd2, 7'd0},
                pwm: {8'h00, 8'h00, 8'hF0, 8'h7F}, brk: 4'b1000};
    // C: ch2 braked -> ch0 650, ch1 104
    vecs[2] = '{tgt: {8'h00, 8'h00, 8'h8A, 8'd50}, enc: {7'd0, 7'd20, 7'd2, 7'd0},
                pwm: {8'h00, 8'h00, 8'hE8, 8'h7F}, brk: 4'b1100};
    // D: ch2 restarts from zeroed state -> 75; ch3 fresh reverse -> 75; ch1 96
    vecs[3] = '{tgt: {8'h85, 8'h05, 8'h8A, 8'd50}, enc: {7'd0, 7'd0, 7'd2, 7'd0},
                pwm: {8'hCB, 8'h4B, 8'hE0, 8'h7F}, brk: 4'b0000};
    // E: ch3 e=127 -> u=1900, stored as 1023
    vecs[4] = '{tgt: {8'h7F, 8'h00, 8'h00, 8'h00}, enc: 28'd0,
                pwm: {8'h7F, 8'h00, 8'h00, 8'h00}, brk: 4'b0111};
    // F: ch3 e=70 -> 1023+1050-2032 = 41 (unclamped history would give 127)
    vecs[5] = '{tgt: {8'h46, 8'h00, 8'h00, 8'h00}, enc: 28'd0,
                pwm: {8'h29, 8'h00, 8'h00, 8'h00}, brk: 4'b0111};

    // Reset state, then hold with no tick.
    repeat (3) @(posedge clk);
    #1 chk_reset_state("reset");
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk_reset_state("idle_hold");

    // Main vector table.
    for (int v = 0; v < 6; v++)
      run_sweep(v, 1'b0, 1'b0);
    chk("no_overrun_yet", 64'(overrun), 64'd0);

    // Extra tick at cycle 4: ignored, done still at 12, same outputs as A.
    run_sweep(0, 1'b1, 1'b0);
    chk("overrun_set", 64'(overrun), 64'd1);
    @(posedge clk); #1;
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // Reset during a sweep, then a sweep that must look like power-up.
    run_sweep(0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_reset_state("post_reset");
    run_sweep(0, 1'b0, 1'b0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
